bcd_lut_arbiter: RTL

Round-robin arbiter that shares the single binary-to-decimal lookup BRAM between several UI requesters (date/time formatter, caller-ID formatter, menu/counter displays). Each requester presents a 7-bit binary value. The arbiter issues at most one BRAM read per cycle, pipelines the reads, and returns the packed two-digit BCD byte to the originating client with a one-hot valid. It sits between the UI formatting blocks and the lookup BRAM, and is the only driver of the BRAM address.

---
 rtl/bcd_lut_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/bcd_lut_arbiter.sv
// Round-robin arbiter sharing the binary-to-BCD lookup BRAM among UI clients.
// Grants one read per cycle and returns the BCD byte with a one-hot client tag.
module bcd_lut_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int RD_LAT      = 1
) (
  input  logic                          clk_27mhz,
  input  logic                          reset_n,
  input  logic [NUM_CLIENTS-1:0]        req,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
  output logic [NUM_CLIENTS-1:0]        gnt,
  output logic [NUM_CLIENTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]             rsp_data,
  output logic [ADDR_W-1:0]             lut_addr,
  input  logic [DATA_W-1:0]             lut_data,
  output logic                          busy
);

  localparam int PTR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  logic [PTR_W-1:0]       r_ptr;
  logic [NUM_CLIENTS-1:0] r_gnt;
  logic [ADDR_W-1:0]      r_lut_addr;
  logic [DATA_W-1:0]      r_rsp_data;
  logic [NUM_CLIENTS-1:0] r_tag [RD_LAT+1];

  logic [NUM_CLIENTS-1:0] w_elig;
  logic                   w_hit;
  logic [PTR_W-1:0]       w_win;
  logic [PTR_W-1:0]       w_ptr_nxt;
  logic [NUM_CLIENTS-1:0] w_gnt_nxt;
  logic [ADDR_W-1:0]      w_win_addr;
  logic                   w_busy;

  // A client is ineligible while its own gnt pulse is showing.
  assign w_elig = req & ~r_gnt;

  always_comb begin
    w_hit = 1'b0;
    w_win = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (!w_hit &&
          w_elig[(int'(r_ptr) + i) % NUM_CLIENTS]) begin
        w_hit = 1'b1;
        w_win = PTR_W'((int'(r_ptr) + i) % NUM_CLIENTS);
      end
    end
  end

  always_comb begin
    w_ptr_nxt = w_win + PTR_W'(1);
    if (w_win == PTR_W'(NUM_CLIENTS - 1))
      w_ptr_nxt = '0;
  end

  assign w_gnt_nxt  = w_hit ? (NUM_CLIENTS'(1) << w_win) : '0;
  assign w_win_addr = req_addr[int'(w_win)*ADDR_W +: ADDR_W];

  always_ff @(posedge clk_27mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt      <= '0;
      r_ptr      <= '0;
      r_lut_addr <= '0;
    end else begin
      r_gnt <= w_gnt_nxt;
      if (w_hit) begin
        r_ptr      <= w_ptr_nxt;
        r_lut_addr <= w_win_addr;
      end
    end
  end

  // Tag pipeline tracks which client owns each BRAM read in flight.
  always_ff @(posedge clk_27mhz or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s <= RD_LAT; s++)
        r_tag[s] <= '0;
      r_rsp_data <= '0;
    end else begin
      r_tag[0] <= r_gnt;
      for (int s = 1; s <= RD_LAT; s++)
        r_tag[s] <= r_tag[s-1];
      if (|r_tag[RD_LAT-1])
        r_rsp_data <= lut_data;
    end
  end

  always_comb begin
    w_busy = 1'b0;
    for (int s = 0; s <= RD_LAT; s++)
      w_busy = w_busy | (|r_tag[s]);
  end

  assign gnt       = r_gnt;
  assign lut_addr  = r_lut_addr;
  assign rsp_valid = r_tag[RD_LAT];
  assign rsp_data  = r_rsp_data;
  assign busy      = w_busy;

  a_gnt_onehot: assert property (
    @(posedge clk_27mhz) disable iff (!reset_n)
    $onehot0(r_gnt));

  a_rsp_onehot: assert property (
    @(posedge clk_27mhz) disable iff (!reset_n)
    $onehot0(r_tag[RD_LAT]));

  a_no_regrant: assert property (
    @(posedge clk_27mhz) disable iff (!reset_n)
    (r_gnt & w_gnt_nxt) == '0);

endmodule
